// File: rtl/bcd_field_counter_if.sv
// rtl/bcd_field_counter_if.sv - control and value bundle for one BCD field counter
interface bcd_field_counter_if;
    logic       enable;
    logic       carry_in;
    logic [1:0] set_state;
    logic       inc;
    logic       dec;
    logic [7:0] max_dyn;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] cnt_hi;
    logic [3:0] cnt_lo;
    logic       carry_out;
    logic       load_err;
    logic       clamp_pulse;

    modport master (
        output enable, carry_in, set_state, inc, dec, max_dyn, load, load_val,
        input  cnt_hi, cnt_lo, carry_out, load_err, clamp_pulse
    );

    modport slave (
        input  enable, carry_in, set_state, inc, dec, max_dyn, load, load_val,
        output cnt_hi, cnt_lo, carry_out, load_err, clamp_pulse
    );
endinterface

// File: rtl/bcd_field_counter.sv
// rtl/bcd_field_counter.sv - 2-digit BCD calendar/time field counter with carry chain, set mode and load
module bcd_field_counter #(
    parameter logic [7:0] MIN_VAL     = 8'h01,
    parameter logic [7:0] MAX_VAL     = 8'h12,
    parameter logic [7:0] RESET_VAL   = 8'h01,
    parameter bit         USE_DYN_MAX = 1'b0
) (
    input logic                CLK,
    input logic                RESET,
    bcd_field_counter_if.slave bus
);

    // With both nibbles held to 0-9, raw 8-bit compares order BCD values numerically.
    function automatic logic is_bcd(input logic [7:0] x);
        return (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] x);
        if (x[3:0] == 4'd9)
            return {x[7:4] + 4'd1, 4'd0};
        return {x[7:4], x[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] x);
        if (x[3:0] == 4'd0)
            return {x[7:4] - 4'd1, 4'd9};
        return {x[7:4], x[3:0] - 4'd1};
    endfunction

    logic [7:0] v;
    logic [7:0] v_next;
    logic [7:0] emax;
    logic       dyn_ok;
    logic       clamp;
    logic       run;
    logic       sup;
    logic       sdn;
    logic       load_ok;
    logic       at_max;

    always_comb begin
        dyn_ok = USE_DYN_MAX && is_bcd(bus.max_dyn) && (bus.max_dyn >= MIN_VAL);
        emax   = MAX_VAL;
        if (dyn_ok && (bus.max_dyn < MAX_VAL))
            emax = bus.max_dyn;
    end

    assign run     = (bus.set_state == 2'b01) && bus.enable && bus.carry_in;
    assign sup     = bus.set_state[1] && bus.inc && !bus.dec;
    assign sdn     = bus.set_state[1] && bus.dec && !bus.inc;
    assign clamp   = v > emax;
    assign at_max  = v >= emax;
    assign load_ok = is_bcd(bus.load_val) && (bus.load_val >= MIN_VAL) && (bus.load_val <= emax);

    always_comb begin
        v_next = v;
        if (bus.load) begin
            if (load_ok)
                v_next = bus.load_val;
        end else if (clamp) begin
            v_next = emax;
        end else if (run || sup) begin
            v_next = at_max ? MIN_VAL : bcd_inc(v);
        end else if (sdn) begin
            v_next = (v <= MIN_VAL) ? emax : bcd_dec(v);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            v               <= RESET_VAL;
            bus.load_err    <= 1'b0;
            bus.clamp_pulse <= 1'b0;
        end else begin
            v               <= v_next;
            bus.load_err    <= bus.load && !load_ok;
            bus.clamp_pulse <= !bus.load && clamp;
        end
    end

    // Set-mode edits never ripple into the next field; only a run-mode wrap does.
    assign bus.carry_out = run && at_max && !bus.load && !clamp && !RESET;
    assign bus.cnt_hi    = v[7:4];
    assign bus.cnt_lo    = v[3:0];

endmodule

// File: tb/tb_bcd_field_counter.sv
// tb/tb_bcd_field_counter.sv - directed vector bench for bcd_field_counter
module tb_bcd_field_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ab;
    logic rst_c;
    int   checks   = 0;
    int   failures = 0;

    bcd_field_counter_if ia ();
    bcd_field_counter_if ib ();
    bcd_field_counter_if ic ();

    bcd_field_counter dut_a (.CLK(clk), .RESET(rst_ab), .bus(ia));

    bcd_field_counter #(
        .MIN_VAL(8'h01), .MAX_VAL(8'h31), .RESET_VAL(8'h01), .USE_DYN_MAX(1'b1)
    ) dut_b (.CLK(clk), .RESET(rst_ab), .bus(ib));

    bcd_field_counter #(
        .MIN_VAL(8'h00), .MAX_VAL(8'h23), .RESET_VAL(8'h00), .USE_DYN_MAX(1'b0)
    ) dut_c (.CLK(clk), .RESET(rst_c), .bus(ic));

    typedef struct {
        bit         sel;
        logic [1:0] ss;
        logic       en, ci, inc, dec, ld;
        logic [7:0] lv, md;
        logic [7:0] ev;
        logic       ec, eerr, eclamp;
    } vec_t;

    vec_t q[$];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit sel, input logic [1:0] ss, input logic en, input logic ci,
                       input logic inc, input logic dec, input logic ld, input logic [7:0] lv,
                       input logic [7:0] md, input logic [7:0] ev, input logic ec,
                       input logic eerr, input logic eclamp);
        vec_t t;
        t.sel = sel; t.ss = ss; t.en = en; t.ci = ci; t.inc = inc; t.dec = dec;
        t.ld = ld; t.lv = lv; t.md = md; t.ev = ev; t.ec = ec; t.eerr = eerr; t.eclamp = eclamp;
        q.push_back(t);
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] h;
        logic [3:0] l;
        h = 4'(n / 10);
        l = 4'(n % 10);
        return {h, l};
    endfunction

    task automatic drive(input vec_t t);
        if (!t.sel) begin
            ia.set_state = t.ss; ia.enable = t.en; ia.carry_in = t.ci; ia.inc = t.inc;
            ia.dec = t.dec; ia.load = t.ld; ia.load_val = t.lv; ia.max_dyn = t.md;
        end else begin
            ib.set_state = t.ss; ib.enable = t.en; ib.carry_in = t.ci; ib.inc = t.inc;
            ib.dec = t.dec; ib.load = t.ld; ib.load_val = t.lv; ib.max_dyn = t.md;
        end
    endtask

    initial begin
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        ia.set_state = 2'b00; ia.enable = 0; ia.carry_in = 0; ia.inc = 0; ia.dec = 0;
        ia.load = 0; ia.load_val = 8'h00; ia.max_dyn = 8'h00;
        ib.set_state = 2'b00; ib.enable = 0; ib.carry_in = 0; ib.inc = 0; ib.dec = 0;
        ib.load = 0; ib.load_val = 8'h00; ib.max_dyn = 8'h31;
        ic.set_state = 2'b00; ic.enable = 0; ic.carry_in = 0; ic.inc = 0; ic.dec = 0;
        ic.load = 0; ic.load_val = 8'h00; ic.max_dyn = 8'h00;

        // Default field: run count 01..12 and wrap
        for (int k = 2; k <= 13; k++)
            add(0, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h00, (k == 13) ? 8'h01 : to_bcd(k), k == 13, 0, 0);
        add(0, 2'b01, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add(0, 2'b01, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        add(0, 2'b00, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        // Set mode wrap both ways, no ripple
        add(0, 2'b10, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0);
        add(0, 2'b10, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        for (int k = 2; k <= 5; k++)
            add(0, 2'b10, 1, 1, 1, 0, 0, 8'h00, 8'h00, to_bcd(k), 0, 0, 0);
        add(0, 2'b10, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);
        add(0, 2'b11, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 8'h10, 8'h00, 8'h10, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h09, 0, 0, 0);
        // Loads: rejected above max, non-BCD, below min; accepted over RUN
        add(0, 2'b00, 0, 0, 0, 0, 1, 8'h13, 8'h00, 8'h09, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 8'h1A, 8'h00, 8'h09, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h09, 0, 1, 0);
        add(0, 2'b01, 1, 1, 0, 0, 1, 8'h07, 8'h00, 8'h07, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 8'h12, 8'h00, 8'h12, 0, 0, 0);
        add(0, 2'b01, 1, 1, 0, 0, 1, 8'h03, 8'h00, 8'h03, 0, 0, 0);
        add(0, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h04, 0, 0, 0);

        // Day field 01..31 with runtime max
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h28, 8'h28, 8'h28, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h28, 8'h01, 1, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h29, 8'h28, 8'h01, 0, 1, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h28, 8'h31, 8'h28, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h31, 8'h29, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h3A, 8'h30, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h3A, 8'h31, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h3A, 8'h01, 1, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h31, 8'h00, 8'h31, 0, 0, 0);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h30, 8'h30, 0, 0, 1);
        add(1, 2'b01, 1, 1, 0, 0, 0, 8'h00, 8'h30, 8'h01, 1, 0, 0);
        add(1, 2'b10, 0, 0, 0, 1, 0, 8'h00, 8'h28, 8'h28, 0, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h15, 8'h20, 8'h15, 0, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 8'h25, 8'h20, 8'h15, 0, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        #1;
        chk("reset_a_v", 0, {ia.cnt_hi, ia.cnt_lo}, 8'h01);
        chk("reset_a_err", 0, {7'd0, ia.load_err}, 8'h00);
        chk("reset_a_clamp", 0, {7'd0, ia.clamp_pulse}, 8'h00);
        chk("reset_c_v", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h00);

        foreach (q[i]) begin
            @(negedge clk);
            drive(q[i]);
            #1;
            chk("carry", i, {7'd0, q[i].sel ? ib.carry_out : ia.carry_out}, {7'd0, q[i].ec});
            @(posedge clk);
            #1;
            chk("v", i, q[i].sel ? {ib.cnt_hi, ib.cnt_lo} : {ia.cnt_hi, ia.cnt_lo}, q[i].ev);
            chk("load_err", i, {7'd0, q[i].sel ? ib.load_err : ia.load_err}, {7'd0, q[i].eerr});
            chk("clamp", i, {7'd0, q[i].sel ? ib.clamp_pulse : ia.clamp_pulse}, {7'd0, q[i].eclamp});
        end

        // Hour field 00..23: async reset between edges, then resume
        @(negedge clk);
        ic.set_state = 2'b01; ic.enable = 1; ic.carry_in = 1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk("c_count", k, {ic.cnt_hi, ic.cnt_lo}, to_bcd(k));
        end
        @(negedge clk);
        ic.load = 1; ic.load_val = 8'h99;
        @(posedge clk);
        #1;
        chk("c_bad_load_v", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h09);
        chk("c_bad_load_err", 0, {7'd0, ic.load_err}, 8'h01);
        @(negedge clk);
        ic.load = 0;
        #2;
        rst_c = 1'b1;
        #1;
        chk("c_rst_v", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h00);
        chk("c_rst_err", 0, {7'd0, ic.load_err}, 8'h00);
        chk("c_rst_carry", 0, {7'd0, ic.carry_out}, 8'h00);
        @(posedge clk);
        #1;
        chk("c_rst_hold", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h00);
        @(negedge clk);
        ic.load = 1; ic.load_val = 8'h23;
        #1;
        chk("c_rst_carry", 1, {7'd0, ic.carry_out}, 8'h00);
        rst_c = 1'b0;
        @(posedge clk);
        #1;
        chk("c_load_23", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h23);
        @(negedge clk);
        ic.load = 0;
        #1;
        chk("c_wrap_carry", 0, {7'd0, ic.carry_out}, 8'h01);
        rst_c = 1'b1;
        #1;
        chk("c_rst_carry", 2, {7'd0, ic.carry_out}, 8'h00);
        chk("c_rst_v", 1, {ic.cnt_hi, ic.cnt_lo}, 8'h00);
        @(negedge clk);
        rst_c = 1'b0;
        @(posedge clk);
        #1;
        chk("c_resume", 0, {ic.cnt_hi, ic.cnt_lo}, 8'h01);
        @(posedge clk);
        #1;
        chk("c_resume", 1, {ic.cnt_hi, ic.cnt_lo}, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
